// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the alu command sequencer slice:
//   - DATA_W            datapath width
//   - OP_*              alu opCode encodings (0..8 arithmetic/logic, 15 LOADI)
//   - *_MSB / *_LSB     instruction word field positions
//   - state_t           sequencer FSM state encoding
//   - is_legal_op()     true for opCodes the sequencer executes
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SHL   = 4'd4;
    localparam logic [3:0] OP_SHR   = 4'd5;
    localparam logic [3:0] OP_SRA   = 4'd6;
    localparam logic [3:0] OP_GT    = 4'd7;
    localparam logic [3:0] OP_LT    = 4'd8;
    localparam logic [3:0] OP_LOADI = 4'd15;

    // Instruction word layout
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int SH_MSB  = 27;
    localparam int SH_LSB  = 23;
    localparam int RD_MSB  = 22;
    localparam int RD_LSB  = 20;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 17;
    localparam int RS2_MSB = 16;
    localparam int RS2_LSB = 14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Codes 9..14 are reserved and reported as errors
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_LT) || (op == OP_LOADI);
    endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational alu driven by the sequencer.
// Ports:
//   in1, in2    [31:0] operands (treated as signed for sra/gt/lt)
//   op_code     [3:0]  operation select (OP_ADD..OP_LT)
//   shift_amt   [4:0]  shift distance for shl/shr/sra (applied to in1)
//   result      [31:0] operation result; 0 for unsupported codes
// ---------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [3:0]        op_code,
    input  logic [4:0]        shift_amt,
    output logic [DATA_W-1:0] result
);

    logic signed [DATA_W-1:0] in1_s;
    logic signed [DATA_W-1:0] in2_s;

    assign in1_s = in1;
    assign in2_s = in2;

    always_comb begin
        result = '0;
        case (op_code)
            OP_ADD: result = in1 + in2;
            OP_SUB: result = in1 - in2;
            OP_AND: result = in1 & in2;
            OP_OR:  result = in1 | in2;
            OP_SHL: result = in1 << shift_amt;
            OP_SHR: result = in1 >> shift_amt;
            OP_SRA: result = in1_s >>> shift_amt;
            OP_GT:  result = {{(DATA_W-1){1'b0}}, (in1_s > in2_s)};
            OP_LT:  result = {{(DATA_W-1){1'b0}}, (in1_s < in2_s)};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
// NREGS x 32 register file: two asynchronous read ports, one synchronous
// write port, asynchronous clear. R0 always reads as zero and ignores writes.
// Ports:
//   clk, rst_n             clock, asynchronous active-low clear
//   raddr1, raddr2 [2:0]   read indices (upper bits ignored when NREGS < 8)
//   rdata1, rdata2 [31:0]  read data
//   we                     write enable
//   waddr [2:0]            write index
//   wdata [31:0]           write data
// ---------------------------------------------------------------------------
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [DATA_W-1:0] regs [NREGS];
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [AW-1:0]     wa;

    assign ra1 = raddr1[AW-1:0];
    assign ra2 = raddr2[AW-1:0];
    assign wa  = waddr[AW-1:0];

    // R0 is forced to zero on read so its storage never matters
    assign rdata1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rdata2 = (ra2 == '0) ? '0 : regs[ra2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wdata;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Accepts 32-bit instruction words, reads operands from a local register
// file, runs them through one alu, writes the result back and returns it on
// a valid/ready response port. One instruction in flight at a time.
// Optional feature macro: ALU_STATUS_FLAGS_EN adds rsp_zero / rsp_neg.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  instruction handshake; cmd_instr [31:0] word
//                        [31:28] op [27:23] shamt [22:20] rd [19:17] rs1
//                        [16:14] rs2 [13:0] imm
//   rsp_valid/rsp_ready  response handshake
//   rsp_result [31:0]    value written to rd (0 on error)
//   rsp_rd [2:0]         destination index of the response
//   rsp_err              reserved opCode, no write-back
//   busy                 sequencer not idle
//   rsp_zero, rsp_neg    (ALU_STATUS_FLAGS_EN only) result flags
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int IMM_W = 14
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_instr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [2:0]        rsp_rd,
    output logic              rsp_err,
`ifdef ALU_STATUS_FLAGS_EN
    output logic              rsp_zero,
    output logic              rsp_neg,
`endif
    output logic              busy
);

    state_t            state;
    logic [31:0]       instr_q;

    logic [3:0]        op_q;
    logic [4:0]        sh_q;
    logic [2:0]        rd_q;
    logic [2:0]        rs1_q;
    logic [2:0]        rs2_q;
    logic [DATA_W-1:0] imm_ext;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] exec_result;
    logic              exec_err;
    logic              rf_we;

    assign op_q    = instr_q[OPC_MSB:OPC_LSB];
    assign sh_q    = instr_q[SH_MSB:SH_LSB];
    assign rd_q    = instr_q[RD_MSB:RD_LSB];
    assign rs1_q   = instr_q[RS1_MSB:RS1_LSB];
    assign rs2_q   = instr_q[RS2_MSB:RS2_LSB];
    assign imm_ext = {{(DATA_W-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    assign exec_err = !is_legal_op(op_q);

    // Write-back happens on the EXEC->RESP edge; operands were read from the
    // pre-edge register contents, so rd may alias rs1/rs2 safely.
    assign rf_we = (state == S_EXEC) && !exec_err;

    alu_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1_q),
        .raddr2 (rs2_q),
        .rdata1 (op1),
        .rdata2 (op2),
        .we     (rf_we),
        .waddr  (rd_q),
        .wdata  (exec_result)
    );

    alu u_alu (
        .in1       (op1),
        .in2       (op2),
        .op_code   (op_q),
        .shift_amt (sh_q),
        .result    (alu_result)
    );

    // LOADI bypasses the alu; reserved codes produce a zero result
    always_comb begin
        exec_result = '0;
        if (op_q == OP_LOADI) begin
            exec_result = imm_ext;
        end else if (op_q <= OP_LT) begin
            exec_result = alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            instr_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_rd     <= '0;
            rsp_err    <= 1'b0;
`ifdef ALU_STATUS_FLAGS_EN
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        instr_q <= cmd_instr;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= exec_result;
                    rsp_rd     <= rd_q;
                    rsp_err    <= exec_err;
`ifdef ALU_STATUS_FLAGS_EN
                    rsp_zero   <= !exec_err && (exec_result == '0);
                    rsp_neg    <= !exec_err && exec_result[DATA_W-1];
`endif
                    state      <= S_RESP;
                end
                S_RESP: begin
                    // Response fields hold until the consumer takes them
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed testbench for alu_cmd_sequencer with hand-computed expectations.
// Honours ALU_STATUS_FLAGS_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_instr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_rd;
    logic        rsp_err;
    logic        busy;
`ifdef ALU_STATUS_FLAGS_EN
    logic        rsp_zero;
    logic        rsp_neg;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;

    alu_cmd_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_instr  (cmd_instr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_rd     (rsp_rd),
        .rsp_err    (rsp_err),
`ifdef ALU_STATUS_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_neg    (rsp_neg),
`endif
        .busy       (busy)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds an instruction word from its fields
    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] sh,
                                       input logic [2:0] rd, input logic [2:0] rs1,
                                       input logic [2:0] rs2, input logic [13:0] imm);
        return {op, sh, rd, rs1, rs2, imm};
    endfunction

    // One comparison; counts and reports
    task automatic check_output(input logic [31:0] observed, input logic [31:0] expected,
                                input string tag);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Issues one instruction with rsp_ready high and checks the full
    // accept -> EXEC -> RESP -> IDLE timeline
    task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] exp_res,
                                  input logic [2:0] exp_rd, input logic exp_err,
                                  input string tag);
        @(negedge clk);
        check_output(32'(cmd_ready), 32'd1, {tag, " cmd_ready"});
        cmd_valid = 1'b1;
        cmd_instr = instr;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_output(32'(busy), 32'd1, {tag, " busy_exec"});
        check_output(32'(rsp_valid), 32'd0, {tag, " rsp_valid_exec"});
        @(posedge clk);
        #1;
        check_output(32'(rsp_valid), 32'd1, {tag, " rsp_valid"});
        check_output(rsp_result, exp_res, {tag, " rsp_result"});
        check_output(32'(rsp_rd), 32'(exp_rd), {tag, " rsp_rd"});
        check_output(32'(rsp_err), 32'(exp_err), {tag, " rsp_err"});
`ifdef ALU_STATUS_FLAGS_EN
        check_output(32'(rsp_zero), 32'(!exp_err && (exp_res == 32'd0)), {tag, " rsp_zero"});
        check_output(32'(rsp_neg), 32'(!exp_err && exp_res[31]), {tag, " rsp_neg"});
`endif
        @(posedge clk);
        #1;
        check_output(32'(rsp_valid), 32'd0, {tag, " rsp_valid_done"});
        check_output(32'(busy), 32'd0, {tag, " busy_done"});
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_instr = '0;
        rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_output(32'(rsp_valid), 32'd0, "reset rsp_valid");
        check_output(rsp_result, 32'd0, "reset rsp_result");
        check_output(32'(rsp_rd), 32'd0, "reset rsp_rd");
        check_output(32'(rsp_err), 32'd0, "reset rsp_err");
        check_output(32'(busy), 32'd0, "reset busy");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output(32'(cmd_ready), 32'd1, "post-reset cmd_ready");

        // Basic LOADI / ADD
        apply_stimulus(mk(4'd15, 5'd0, 3'd1, 3'd0, 3'd0, 14'd5),     32'd5,        3'd1, 1'b0, "loadi r1=5");
        apply_stimulus(mk(4'd15, 5'd0, 3'd2, 3'd0, 3'd0, 14'h3FF9),  32'hFFFFFFF9, 3'd2, 1'b0, "loadi r2=-7");
        apply_stimulus(mk(4'd0,  5'd0, 3'd3, 3'd1, 3'd2, 14'd0),     32'hFFFFFFFE, 3'd3, 1'b0, "add r3");

        // Shifts and signed compares
        apply_stimulus(mk(4'd15, 5'd0, 3'd1, 3'd0, 3'd0, 14'h3FF0),  32'hFFFFFFF0, 3'd1, 1'b0, "loadi r1=-16");
        apply_stimulus(mk(4'd6,  5'd2, 3'd4, 3'd1, 3'd0, 14'd0),     32'hFFFFFFFC, 3'd4, 1'b0, "sra r4");
        apply_stimulus(mk(4'd5,  5'd2, 3'd5, 3'd1, 3'd0, 14'd0),     32'h3FFFFFFC, 3'd5, 1'b0, "shr r5");
        apply_stimulus(mk(4'd7,  5'd0, 3'd6, 3'd2, 3'd1, 14'd0),     32'd1,        3'd6, 1'b0, "gt r6");
        apply_stimulus(mk(4'd8,  5'd0, 3'd6, 3'd2, 3'd1, 14'd0),     32'd0,        3'd6, 1'b0, "lt r6");

        // Reserved opCode leaves R3 untouched
        apply_stimulus(mk(4'd10, 5'd0, 3'd3, 3'd1, 3'd2, 14'd0),     32'd0,        3'd3, 1'b1, "illegal op10");
        apply_stimulus(mk(4'd3,  5'd0, 3'd7, 3'd3, 3'd0, 14'd0),     32'hFFFFFFFE, 3'd7, 1'b0, "read r3");

        // Remaining ops, R0 behaviour and aliasing
        apply_stimulus(mk(4'd2,  5'd0, 3'd7, 3'd3, 3'd5, 14'd0),     32'h3FFFFFFC, 3'd7, 1'b0, "and r7");
        apply_stimulus(mk(4'd1,  5'd0, 3'd7, 3'd0, 3'd2, 14'd0),     32'd7,        3'd7, 1'b0, "sub r7");
        apply_stimulus(mk(4'd4,  5'd4, 3'd7, 3'd2, 3'd0, 14'd0),     32'hFFFFFF90, 3'd7, 1'b0, "shl r7");
        apply_stimulus(mk(4'd0,  5'd0, 3'd7, 3'd2, 3'd2, 14'd0),     32'hFFFFFFF2, 3'd7, 1'b0, "add wrap");
        apply_stimulus(mk(4'd15, 5'd0, 3'd0, 3'd0, 3'd0, 14'd5),     32'd5,        3'd0, 1'b0, "loadi r0");
        apply_stimulus(mk(4'd0,  5'd0, 3'd7, 3'd0, 3'd0, 14'd0),     32'd0,        3'd7, 1'b0, "read r0");
        apply_stimulus(mk(4'd0,  5'd0, 3'd1, 3'd1, 3'd1, 14'd0),     32'hFFFFFFE0, 3'd1, 1'b0, "add r1=r1+r1");
        apply_stimulus(mk(4'd3,  5'd0, 3'd7, 3'd1, 3'd0, 14'd0),     32'hFFFFFFE0, 3'd7, 1'b0, "read r1");

        // Response backpressure with a competing command held valid
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_instr = mk(4'd15, 5'd0, 3'd1, 3'd0, 3'd0, 14'd9);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_instr = mk(4'd15, 5'd0, 3'd2, 3'd0, 3'd0, 14'd3);
        @(posedge clk);
        #1;
        check_output(32'(rsp_valid), 32'd1, "bp rsp_valid");
        check_output(rsp_result, 32'd9, "bp rsp_result");
        repeat (5) begin
            @(posedge clk);
            #1;
            check_output(32'(cmd_ready), 32'd0, "bp cmd_ready");
            check_output(32'(rsp_valid), 32'd1, "bp hold valid");
            check_output(rsp_result, 32'd9, "bp hold result");
            check_output(32'(rsp_rd), 32'd1, "bp hold rd");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output(32'(rsp_valid), 32'd0, "bp released valid");
        check_output(32'(cmd_ready), 32'd1, "bp released ready");
        apply_stimulus(mk(4'd3, 5'd0, 3'd7, 3'd2, 3'd0, 14'd0), 32'hFFFFFFF9, 3'd7, 1'b0, "r2 not overwritten");
        apply_stimulus(mk(4'd3, 5'd0, 3'd7, 3'd1, 3'd0, 14'd0), 32'd9,        3'd7, 1'b0, "r1 loaded under bp");

        // Asynchronous reset in the middle of EXEC
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_instr = mk(4'd15, 5'd0, 3'd3, 3'd0, 3'd0, 14'h55);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_output(32'(busy), 32'd1, "mid-exec busy");
        rst_n = 1'b0;
        #1;
        check_output(32'(rsp_valid), 32'd0, "rst exec rsp_valid");
        check_output(rsp_result, 32'd0, "rst exec rsp_result");
        check_output(32'(rsp_rd), 32'd0, "rst exec rsp_rd");
        check_output(32'(rsp_err), 32'd0, "rst exec rsp_err");
        check_output(32'(busy), 32'd0, "rst exec busy");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output(32'(cmd_ready), 32'd1, "rst exec cmd_ready");
        apply_stimulus(mk(4'd15, 5'd0, 3'd1, 3'd0, 3'd0, 14'h1FFF), 32'd8191, 3'd1, 1'b0, "loadi r1=8191");
        apply_stimulus(mk(4'd0,  5'd0, 3'd2, 3'd1, 3'd0, 14'd0),    32'd8191, 3'd2, 1'b0, "add r2=r1+r0");
        apply_stimulus(mk(4'd3,  5'd0, 3'd7, 3'd3, 3'd0, 14'd0),    32'd0,    3'd7, 1'b0, "r3 cleared");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Safety net so a stuck run still ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
